// File: rtl/spart_tx_fifo.sv
// rtl/spart_tx_fifo.sv - SPART transmit byte FIFO, first-word-fall-through, valid/ready drain.
// Optional macro SPART_TX_FIFO_STATS_EN adds overflow/drop_cnt statistics ports.
module spart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          send,
  input  logic [7:0]    send_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready
`ifdef SPART_TX_FIFO_STATS_EN
  ,
  output logic          overflow,
  output logic [7:0]    drop_cnt
`endif
);

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Flags come from registered count only, so no input reaches an output combinationally.
  assign w_full  = (r_count == L_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = send & ~w_full;
  assign w_pop   = ~w_empty & tx_ready;

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign tx_valid = ~w_empty;
  assign tx_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr_ptr] <= send_data;
  end

`ifdef SPART_TX_FIFO_STATS_EN
  logic       r_overflow;
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  assign w_drop   = send & w_full;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_spart_tx_fifo.sv
// tb/tb_spart_tx_fifo.sv - randomized and directed checks of spart_tx_fifo against a queue model.
module tb_spart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       tx_ready = 1'b0;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       tx_valid;
  logic [7:0] tx_data;
`ifdef SPART_TX_FIFO_STATS_EN
  logic       overflow;
  logic [7:0] drop_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_q[$];
  bit         m_ovf = 0;
  int         m_drops = 0;

  always #5 clk = ~clk;

  spart_tx_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk(clk),
    .rst(rst),
    .send(send),
    .send_data(send_data),
    .full(full),
    .empty(empty),
    .count(count),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready)
`ifdef SPART_TX_FIFO_STATS_EN
    ,
    .overflow(overflow),
    .drop_cnt(drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(m_q.size()));
    chk({tag, "_full"}, 32'(full), 32'(m_q.size() == 8));
    chk({tag, "_empty"}, 32'(empty), 32'(m_q.size() == 0));
    chk({tag, "_valid"}, 32'(tx_valid), 32'(m_q.size() != 0));
    chk({tag, "_data"}, 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
`ifdef SPART_TX_FIFO_STATS_EN
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, "_drops"}, 32'(drop_cnt), 32'(m_drops));
`endif
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare after the edge.
  task automatic step(input string tag, input logic s, input logic [7:0] d, input logic r);
    bit was_full;
    send = s;
    send_data = d;
    tx_ready = r;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_ovf = 0;
      m_drops = 0;
    end else begin
      was_full = (m_q.size() == 8);
      if (s && was_full) begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
      if (r && m_q.size() != 0) void'(m_q.pop_front());
      if (s && !was_full) m_q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input logic s, input logic r);
    rst = 1'b1;
    step("rst", s, 8'hEE, r);
    rst = 1'b0;
  endtask

  initial begin
    do_reset(1'b0, 1'b0);
    do_reset(1'b1, 1'b1);

    // Basic push with no drain.
    step("t1", 1'b1, 8'h41, 1'b0);
    step("t1", 1'b1, 8'h42, 1'b0);
    step("t1", 1'b1, 8'h43, 1'b0);
    chk("t1_head", 32'(tx_data), 32'h41);
    chk("t1_cnt3", 32'(count), 32'd3);

    // Fill to full, then an overflowing send.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step("t2", 1'b1, 8'(8'h10 + i), 1'b0);
    chk("t2_full", 32'(full), 32'd1);
    step("t2_ovf", 1'b1, 8'h99, 1'b0);
    chk("t2_cnt8", 32'(count), 32'd8);

    // Drain in order.
    for (int i = 0; i < 8; i++) begin
      chk("t3_order", 32'(tx_data), 32'(8'h10 + i));
      step("t3", 1'b0, 8'h00, 1'b1);
    end
    chk("t3_empty", 32'(empty), 32'd1);
    step("t3_idle_ready", 1'b0, 8'h00, 1'b1);

    // No bypass while empty.
    step("nobypass", 1'b1, 8'h3C, 1'b1);
    chk("nobypass_cnt", 32'(count), 32'd1);
    step("nobypass2", 1'b0, 8'h00, 1'b1);

    // Steady push/pop at count 4 across wrap.
    for (int i = 0; i < 4; i++) step("t4_fill", 1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 20; i++) step("t4", 1'b1, 8'(i), 1'b1);
    chk("t4_cnt4", 32'(count), 32'd4);

    // Push while full with simultaneous pop: push rejected, then retry.
    for (int i = 0; i < 4; i++) step("t5_fill", 1'b1, 8'(8'hB0 + i), 1'b0);
    step("t5_both", 1'b1, 8'h77, 1'b1);
    chk("t5_cnt7", 32'(count), 32'd7);
    step("t5_retry", 1'b1, 8'h77, 1'b0);
    chk("t5_cnt8", 32'(count), 32'd8);

    // Reset mid-occupancy.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("t6_fill", 1'b1, 8'(8'hC0 + i), 1'b0);
    do_reset(1'b1, 1'b1);
    chk("t6_cnt0", 32'(count), 32'd0);
    step("t6_push", 1'b1, 8'h55, 1'b0);
    chk("t6_head", 32'(tx_data), 32'h55);

    // Random traffic with varying send/ready bias.
    for (int blk = 0; blk < 6; blk++) begin
      int ps = $urandom_range(20, 90);
      int pr = $urandom_range(20, 90);
      for (int i = 0; i < 80; i++) begin
        step("rnd", 1'($urandom_range(99) < ps), 8'($urandom), 1'($urandom_range(99) < pr));
      end
      if (blk == 3) do_reset(1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
